// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer for a single-port 16-bit word memory
// with registered read data (1-cycle latency). One single-word read or write
// is in flight at a time; grants are round-robin between the two requesters.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN makes port 0 always win contention.
module mem_arbiter #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data,
  output logic          mem_rden,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_readout
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StDone} state_e;

  state_e        state;
  logic          cmd_we;   // latched command direction of the in-flight access
  logic          owner;    // port that owns the in-flight access
  logic          last;     // most recent winner, drives round-robin
  logic          winner;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Pick the winner among current requests and mux its command
  always_comb begin
    winner = req1;
    if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      winner = 1'b0;
`else
      winner = ~last;
`endif
    end
    sel_we    = winner ? we1    : we0;
    sel_addr  = winner ? addr1  : addr0;
    sel_wdata = winner ? wdata1 : wdata0;
  end

  // Sequencer FSM; all outputs except busy are registered here
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= StIdle;
      cmd_we      <= 1'b0;
      owner       <= 1'b0;
      last        <= 1'b1;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_rden    <= 1'b0;
      mem_wren    <= 1'b0;
    end else begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      mem_rden <= 1'b0;
      mem_wren <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req0 || req1) begin
            owner       <= winner;
            last        <= winner;
            cmd_we      <= sel_we;
            // Address/data registers double as the command latch
            mem_address <= sel_addr;
            mem_data    <= sel_wdata;
            mem_rden    <= ~sel_we;
            mem_wren    <= sel_we;
            state       <= StIssue;
          end
        end
        StIssue: begin
          if (cmd_we) begin
            ack0  <= ~owner;
            ack1  <= owner;
            state <= StDone;
          end else begin
            state <= StCapture;
          end
        end
        StCapture: begin
          if (owner) rdata1 <= mem_readout;
          else       rdata0 <= mem_readout;
          ack0  <= ~owner;
          ack1  <= owner;
          state <= StDone;
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign busy = (state != StIdle);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the on-chip 16-bit word memory used in the ECE 385 experiments. It grants one single-word read or write at a time to one of two requesters, such as the CPU datapath and a debug/DMA loader. It drives the memory's `rden`/`wren`/`address`/`data` pins and captures the memory's registered `readout`. It sits between the requesters and the memory instance in both the simulation top level and the synthesized design.

## Interface
Parameters:
- `AW`, 10, address width; matches memory `address`.
- `DW`, 16, data width; matches memory `data`/`readout`.

Ports:
- `Clk`  in  1  single system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1 each  request from port 0/1; held high with stable command until `ackN`.
- `we0`, `we1`  in  1 each  1 = write, 0 = read.
- `addr0`, `addr1`  in  AW each  word address.
- `wdata0`, `wdata1`  in  DW each  write data.
- `ack0`, `ack1`  out  1 each  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  DW each  read result; valid from `ackN` until that port's next read completes.
- `busy`  out  1  high in any state other than IDLE.
- `mem_address`  out  AW  to memory `address`.
- `mem_data`  out  DW  to memory `data`.
- `mem_rden`, `mem_wren`  out  1 each  to memory `rden`/`wren`; never high together.
- `mem_readout`  in  DW  from memory `readout`, which is registered with 1-cycle latency.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE:
  - If any `reqN` is high, select a winner.
  - Latch the winner's `we`/`addr`/`wdata` into command registers and record the winner in `owner`.
  - Go to ISSUE. Otherwise stay.
- ISSUE:
  - Drive `mem_address`/`mem_data` from the latches.
  - Drive `mem_rden = ~we` and `mem_wren = we` for exactly this cycle.
  - Write goes to DONE; read goes to CAPTURE.
- CAPTURE: memory output is now valid; register `mem_readout` into `rdata[owner]`. Go to DONE.
- DONE: `ack[owner] = 1` for this cycle only; go to IDLE.
- Outside ISSUE, `mem_rden = mem_wren = 0`. `mem_address`/`mem_data` hold their last values.
- Arbitration is round-robin:
  - A `last` register records the most recent winner.
  - When both requests are high in IDLE, the port that is not `last` wins.
  - A single requester always wins.
- Requests arriving outside IDLE wait. Input changes after the IDLE latch cycle are ignored.
- A requester that keeps `reqN` high in the IDLE cycle after its `ack` starts a new transaction. This is the required way to issue back-to-back requests.
- Reset mid-operation:
  - FSM returns to IDLE and the in-flight transaction is dropped with no `ack`.
  - A write in ISSUE at reset assertion may or may not land.
- Reset values:
  - State IDLE; `last` = 1, so port 0 wins the first contention.
  - `ack0`/`ack1`/`busy`/`mem_rden`/`mem_wren` = 0.
  - `mem_address`/`mem_data`/`rdata0`/`rdata1` = 0.

## Timing
- Request sampled in IDLE at cycle 0.
- Write: ISSUE at cycle 1, `ack` at cycle 2, so 3 cycles per write.
- Read: ISSUE at cycle 1, CAPTURE at cycle 2, `ack` with `rdata` valid at cycle 3, so 4 cycles per read.
- Earliest next request sample is the cycle after `ack`.
- `rdata`/`ack` are registered outputs. `busy` is decoded from registered state.
- Maximum wait for a continuously requesting port while the other also saturates: one foreign transaction (≤4 cycles) plus its own.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN`:
  - Defined: port 0 always wins contention. `last` is still maintained but ignored, and port 1 can starve.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset, then `req0` write of addr 0x005 / data 0xBEEF -> `mem_wren` high only in cycle 1 with address 0x005, `ack0` in cycle 2; a following `req0` read of 0x005 -> `rdata0` = 0xBEEF with `ack0` 3 cycles after its IDLE sample.
- `req0` and `req1` both raised together and held for 4 transactions (reads of 0x010/0x020) -> grants alternate 0,1,0,1; port 0 first after reset. With `MEM_ARB_FIXED_PRIO_EN`, all grants go to port 0 while `req0` stays high.
- `req1` alone, back-to-back writes 0x001 -> 0x1111, 0x002 -> 0x2222, then reads -> `rdata1` returns 0x1111 then 0x2222; `rdata1` is stable between acks.
- Change `addr0` from 0x030 to 0x031 while in ISSUE/CAPTURE of a read of 0x030 -> access uses 0x030; `rdata0` equals the 0x030 contents.
- Assert `Reset` during CAPTURE -> same-cycle asynchronous return: `busy` = 0, no `ack`, `mem_rden`/`mem_wren` = 0, `rdata` = 0x0000.
- Every cycle of all tests: assertion that `mem_rden & mem_wren` is never 1 and `ack0 & ack1` is never 1.
